// File: rtl/i2c_oled_responder.sv
// i2c_oled_responder: write-only I2C target modelling the display end of an
// SSD1306-style OLED link. It samples SCL/SDA on CLK, ACKs writes to
// OWN_ADDR and turns the control-byte framing (Co, D/C#) into command and
// display-data strobes.
// Optional build macro: I2C_OLED_RSP_GLITCH_FILTER_EN adds a 3-sample
// majority filter on each synchronized bus line (+2 CLK detect latency).
module i2c_oled_responder #(
  parameter logic [6:0] OWN_ADDR = 7'h3C
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic       cmd_valid,
  output logic [7:0] cmd_byte,
  output logic       data_valid,
  output logic [7:0] data_byte,
  output logic       busy,
  output logic       frame_err
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_CTRL,
    ST_CTRL_ACK,
    ST_PAYLOAD,
    ST_PAY_ACK,
    ST_IGNORE
  } state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Synchronizer stages (p0, p1); bus idles high, so they reset to 1
  logic scl_p0, scl_p1, sda_p0, sda_p1;
  // Conditioned line levels and their previous-cycle copies (p2)
  logic scl_line, sda_line, scl_p2, sda_p2;

  state_t     state;
  logic [7:0] shreg;
  logic [2:0] bit_cnt;
  logic       bit_open;
  logic       co, dc;

  logic scl_rise, scl_fall, start_det, stop_det;

  // Two-flop synchronizers for the raw pad levels
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      scl_p0 <= 1'b1;
      scl_p1 <= 1'b1;
      sda_p0 <= 1'b1;
      sda_p1 <= 1'b1;
    end else begin
      scl_p0 <= scl_in;
      scl_p1 <= scl_p0;
      sda_p0 <= sda_in;
      sda_p1 <= sda_p0;
    end
  end

`ifdef I2C_OLED_RSP_GLITCH_FILTER_EN
  logic [1:0] scl_hist, sda_hist;

  // Majority vote over the last three synchronized samples, registered
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      scl_hist <= 2'b11;
      sda_hist <= 2'b11;
      scl_line <= 1'b1;
      sda_line <= 1'b1;
    end else begin
      scl_hist <= {scl_hist[0], scl_p1};
      sda_hist <= {sda_hist[0], sda_p1};
      scl_line <= maj3(scl_p1, scl_hist[0], scl_hist[1]);
      sda_line <= maj3(sda_p1, sda_hist[0], sda_hist[1]);
    end
  end
`else
  // Without the filter the synchronized levels are used directly
  always_comb begin
    scl_line = scl_p1;
    sda_line = sda_p1;
  end
`endif

  // Previous-value copies used for edge detection
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      scl_p2 <= 1'b1;
      sda_p2 <= 1'b1;
    end else begin
      scl_p2 <= scl_line;
      sda_p2 <= sda_line;
    end
  end

  // Bus event decode: SCL edges plus START/STOP (SDA edge while SCL high)
  always_comb begin
    scl_rise  = scl_line & ~scl_p2;
    scl_fall  = ~scl_line & scl_p2;
    start_det = scl_line & scl_p2 & sda_p2 & ~sda_line;
    stop_det  = scl_line & scl_p2 & ~sda_p2 & sda_line;
  end

  // Protocol FSM with registered outputs. A bit is sampled on SCL rise and
  // only counted once SCL falls again, so the SCL rise belonging to a STOP
  // never looks like a partial byte.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= ST_IDLE;
      shreg      <= 8'h00;
      bit_cnt    <= 3'd0;
      bit_open   <= 1'b0;
      co         <= 1'b0;
      dc         <= 1'b0;
      sda_oe     <= 1'b0;
      cmd_valid  <= 1'b0;
      cmd_byte   <= 8'h00;
      data_valid <= 1'b0;
      data_byte  <= 8'h00;
      busy       <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      cmd_valid  <= 1'b0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (start_det || stop_det) begin
        if ((state == ST_CTRL || state == ST_PAYLOAD) && bit_cnt != 3'd0)
          frame_err <= 1'b1;
        bit_cnt  <= 3'd0;
        bit_open <= 1'b0;
        sda_oe   <= 1'b0;
        if (start_det) begin
          state <= ST_ADDR;
          busy  <= 1'b1;
        end else begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      end else begin
        case (state)
          ST_ADDR, ST_CTRL, ST_PAYLOAD: begin
            if (scl_rise) begin
              shreg    <= {shreg[6:0], sda_line};
              bit_open <= 1'b1;
            end else if (scl_fall && bit_open) begin
              bit_open <= 1'b0;
              bit_cnt  <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                case (state)
                  ST_ADDR: begin
                    if (shreg[7:1] == OWN_ADDR) begin
                      if (!shreg[0]) begin
                        sda_oe <= 1'b1;
                        state  <= ST_ADDR_ACK;
                      end else begin
                        frame_err <= 1'b1;
                        state     <= ST_IGNORE;
                      end
                    end else begin
                      state <= ST_IGNORE;
                    end
                  end
                  ST_CTRL: begin
                    co     <= shreg[7];
                    dc     <= shreg[6];
                    if (shreg[5:0] != 6'd0)
                      frame_err <= 1'b1;
                    sda_oe <= 1'b1;
                    state  <= ST_CTRL_ACK;
                  end
                  default: begin
                    if (dc) begin
                      data_valid <= 1'b1;
                      data_byte  <= shreg;
                    end else begin
                      cmd_valid <= 1'b1;
                      cmd_byte  <= shreg;
                    end
                    sda_oe <= 1'b1;
                    state  <= ST_PAY_ACK;
                  end
                endcase
              end
            end
          end
          ST_ADDR_ACK: begin
            if (scl_fall) begin
              sda_oe <= 1'b0;
              state  <= ST_CTRL;
            end
          end
          ST_CTRL_ACK: begin
            if (scl_fall) begin
              sda_oe <= 1'b0;
              state  <= ST_PAYLOAD;
            end
          end
          ST_PAY_ACK: begin
            if (scl_fall) begin
              sda_oe <= 1'b0;
              state  <= co ? ST_CTRL : ST_PAYLOAD;
            end
          end
          default: begin
            // IDLE and IGNORE only leave on START/STOP
            sda_oe <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_oled_responder.sv
// Scoreboard bench for i2c_oled_responder: a bit-banged I2C master drives
// the bus, expected strobes are queued as frames are issued and a monitor
// pops and compares them whenever the DUT raises a strobe.
module tb_i2c_oled_responder;

  localparam int H = 10;  // SCL half period in CLK cycles

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       scl_in, sda_in;
  logic       sda_oe, cmd_valid, data_valid, busy, frame_err;
  logic [7:0] cmd_byte, data_byte;

  typedef struct packed {
    logic [1:0] kind;   // 0 = cmd, 1 = data, 2 = frame_err
    logic [7:0] val;
  } ev_t;

  ev_t  exp_q[$];
  int   total = 0;
  int   bad = 0;
  logic oe_seen = 1'b0;

  // Open-drain bus: the responder can only pull SDA low
  assign scl_in = scl_m;
  assign sda_in = sda_m & ~sda_oe;

  i2c_oled_responder #(.OWN_ADDR(7'h3C)) dut (
    .CLK(CLK), .RST(RST), .scl_in(scl_in), .sda_in(sda_in),
    .sda_oe(sda_oe), .cmd_valid(cmd_valid), .cmd_byte(cmd_byte),
    .data_valid(data_valid), .data_byte(data_byte), .busy(busy),
    .frame_err(frame_err)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push(input logic [1:0] k, input logic [7:0] v);
    ev_t e;
    e.kind = k;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  task automatic pop_cmp(input logic [1:0] k, input logic [7:0] v, input string nm);
    ev_t e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_%s actual=%0h required=none", nm, v);
    end else begin
      e = exp_q.pop_front();
      check({nm, "_kind"}, {30'd0, k}, {30'd0, e.kind});
      check({nm, "_val"}, {24'd0, v}, {24'd0, e.val});
    end
  endtask

  // Monitor: compare every strobe against the head of the expected queue
  always @(negedge CLK) begin
    if (sda_oe) oe_seen = 1'b1;
    if (!RST) begin
      if (cmd_valid && data_valid) check("both_strobes", 32'd1, 32'd0);
      if (cmd_valid)  pop_cmp(2'd0, cmd_byte, "cmd");
      if (data_valid) pop_cmp(2'd1, data_byte, "data");
      if (frame_err)  pop_cmp(2'd2, 8'h00, "ferr");
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic i2c_start();
    sda_m = 1'b0;
    wait_clk(H);
    scl_m = 1'b0;
    wait_clk(H);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0;
    wait_clk(H);
    scl_m = 1'b1;
    wait_clk(H);
    sda_m = 1'b1;
    wait_clk(H);
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      sda_m = b[7-i];
      wait_clk(H);
      scl_m = 1'b1;
      wait_clk(H);
      scl_m = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic exp_ack, input string nm);
    logic ack;
    send_bits(b, 8);
    sda_m = 1'b1;
    wait_clk(H);
    scl_m = 1'b1;
    wait_clk(H / 2);
    ack = ~sda_in;
    check(nm, {31'd0, ack}, {31'd0, exp_ack});
    wait_clk(H - H / 2);
    scl_m = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    wait_clk(4);
    check("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    RST = 1'b0;
    wait_clk(4);
    check("idle_sda_oe", {31'd0, sda_oe}, 32'd0);
    check("idle_cmd_valid", {31'd0, cmd_valid}, 32'd0);
    check("idle_data_valid", {31'd0, data_valid}, 32'd0);
    check("idle_frame_err", {31'd0, frame_err}, 32'd0);
    check("idle_cmd_byte", {24'd0, cmd_byte}, 32'h00);
    check("idle_data_byte", {24'd0, data_byte}, 32'h00);

    // Command stream: control 0x00, three commands
    push(2'd0, 8'hAE);
    push(2'd0, 8'hD5);
    push(2'd0, 8'h80);
    i2c_start();
    check("t1_busy_up", {31'd0, busy}, 32'd1);
    send_byte(8'h78, 1'b1, "t1_ack_addr");
    send_byte(8'h00, 1'b1, "t1_ack_ctrl");
    send_byte(8'hAE, 1'b1, "t1_ack_ae");
    send_byte(8'hD5, 1'b1, "t1_ack_d5");
    send_byte(8'h80, 1'b1, "t1_ack_80");
    i2c_stop();
    check("t1_busy_down", {31'd0, busy}, 32'd0);
    check("t1_cmd_hold", {24'd0, cmd_byte}, 32'h80);

    // Single-byte framing: data 0x55 then command 0xAF
    push(2'd1, 8'h55);
    push(2'd0, 8'hAF);
    i2c_start();
    send_byte(8'h78, 1'b1, "t2_ack_addr");
    send_byte(8'hC0, 1'b1, "t2_ack_ctrl1");
    send_byte(8'h55, 1'b1, "t2_ack_55");
    send_byte(8'h80, 1'b1, "t2_ack_ctrl2");
    send_byte(8'hAF, 1'b1, "t2_ack_af");
    i2c_stop();
    check("t2_data_hold", {24'd0, data_byte}, 32'h55);

    // Foreign address 0x3D: silent
    oe_seen = 1'b0;
    i2c_start();
    send_byte(8'h7A, 1'b0, "t3_nack_addr");
    send_byte(8'h00, 1'b0, "t3_nack_b1");
    send_byte(8'h11, 1'b0, "t3_nack_b2");
    i2c_stop();
    check("t3_oe_never", {31'd0, oe_seen}, 32'd0);

    // Read to own address: NACK plus one frame_err
    push(2'd2, 8'h00);
    oe_seen = 1'b0;
    i2c_start();
    send_byte(8'h79, 1'b0, "t4_nack_read");
    send_byte(8'h00, 1'b0, "t4_nack_b1");
    i2c_stop();
    check("t4_oe_never", {31'd0, oe_seen}, 32'd0);
    check("t4_busy_down", {31'd0, busy}, 32'd0);

    // Data 0x12 then STOP after 4 bits of the next byte
    push(2'd1, 8'h12);
    push(2'd2, 8'h00);
    i2c_start();
    send_byte(8'h78, 1'b1, "t5_ack_addr");
    send_byte(8'h40, 1'b1, "t5_ack_ctrl");
    send_byte(8'h12, 1'b1, "t5_ack_12");
    send_bits(8'hA0, 4);
    i2c_stop();
    check("t5_busy_down", {31'd0, busy}, 32'd0);

    // Reset asserted while the address ACK is being driven
    i2c_start();
    send_bits(8'h78, 8);
    sda_m = 1'b1;
    wait_clk(6);
    check("t6_oe_mid_ack", {31'd0, sda_oe}, 32'd1);
    #2;
    RST = 1'b1;
    #1;
    check("t6_oe_async_rel", {31'd0, sda_oe}, 32'd0);
    check("t6_busy_rst", {31'd0, busy}, 32'd0);
    check("t6_cmd_byte_rst", {24'd0, cmd_byte}, 32'h00);
    wait_clk(3);
    RST = 1'b0;
    scl_m = 1'b1;
    wait_clk(2 * H);
    push(2'd0, 8'hA5);
    i2c_start();
    send_byte(8'h78, 1'b1, "t6_ack_addr");
    send_byte(8'h00, 1'b1, "t6_ack_ctrl");
    send_byte(8'hA5, 1'b1, "t6_ack_a5");
    i2c_stop();

    wait_clk(20);
    check("queue_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
